// File: rtl/esti_pkg.sv
// esti_pkg: shared types and constants for the IMU acceleration SPI reader.
package esti_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
    localparam logic SPI_READ_BIT = 1'b1;
    localparam int CMD_BITS = 8;
    localparam int DATA_BITS = 16;
    localparam int FRAME_BITS = 24;
    typedef logic signed [DATA_BITS-1:0] acc_t;
endpackage

// File: rtl/esti_spi_shifter.sv
// esti_spi_shifter: SPI mode-3 bit engine, runs the setup half-period plus 24 SCLK periods per start.
// Ports: clk, reset (async active-low), start_i (begin frame), miso_i,
//        sclk_o / mosi_o (flop outputs), done_o (last cycle of shifting), data_o (last 16 MISO bits).
module esti_spi_shifter
    import esti_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter logic [CMD_BITS-1:0] CMD = 8'hBF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic                 miso_i,
    output logic                 sclk_o,
    output logic                 mosi_o,
    output logic                 done_o,
    output logic [DATA_BITS-1:0] data_o
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int HW = $clog2(2 * FRAME_BITS + 1);
    logic                 busy_q, busy_d;
    logic [DW-1:0]        div_q, div_d;
    logic [HW-1:0]        hp_q, hp_d;
    logic                 sclk_q, sclk_d;
    logic                 mosi_q, mosi_d;
    logic [CMD_BITS-1:0]  cmd_q, cmd_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 hp_end;
    // Half-period 0 is the setup phase; half-periods 1..48 alternate low/high.
    assign hp_end = busy_q && div_q == DW'(CLK_DIV - 1);
    assign done_o = hp_end && hp_q == HW'(2 * FRAME_BITS);
    always_comb begin
        busy_d = busy_q;
        div_d  = div_q;
        hp_d   = hp_q;
        sclk_d = sclk_q;
        mosi_d = mosi_q;
        cmd_d  = cmd_q;
        data_d = data_q;
        if (start_i) begin
            busy_d = 1'b1;
            div_d  = '0;
            hp_d   = '0;
            sclk_d = 1'b1;
            mosi_d = CMD[CMD_BITS-1];
            cmd_d  = {CMD[CMD_BITS-2:0], 1'b0};
        end else if (busy_q) begin
            div_d = hp_end ? '0 : div_q + 1'b1;
            if (hp_end) begin
                hp_d = hp_q + 1'b1;
                if (done_o) begin
                    busy_d = 1'b0;
                end else if (!hp_q[0]) begin
                    sclk_d = 1'b0;
                    // The command MSB is already on MOSI from setup, so the first fall keeps it.
                    if (hp_q != '0) begin
                        mosi_d = cmd_q[CMD_BITS-1];
                        cmd_d  = {cmd_q[CMD_BITS-2:0], 1'b0};
                    end
                end else begin
                    sclk_d = 1'b1;
                    data_d = {data_q[DATA_BITS-2:0], miso_i};
                end
            end
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= 1'b0;
            div_q  <= '0;
            hp_q   <= '0;
            sclk_q <= 1'b1;
            mosi_q <= 1'b0;
            cmd_q  <= '0;
            data_q <= '0;
        end else begin
            busy_q <= busy_d;
            div_q  <= div_d;
            hp_q   <= hp_d;
            sclk_q <= sclk_d;
            mosi_q <= mosi_d;
            cmd_q  <= cmd_d;
            data_q <= data_d;
        end
    end
    assign sclk_o = sclk_q;
    assign mosi_o = mosi_q;
    assign data_o = data_q;
endmodule

// File: rtl/esti_acc_spi_reader.sv
// esti_acc_spi_reader: periodic SPI read of one signed 16-bit IMU axis, held for the estimator.
// Ports: clk, reset (async active-low), enable, spi_cs_n/spi_sclk/spi_mosi/spi_miso (IMU pins),
//        acc_out (held sample), acc_valid (update pulse), overrun (sticky missed tick).
module esti_acc_spi_reader
    import esti_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int SAMPLE_PERIOD = 1000,
    parameter logic [6:0] REG_ADDR = 7'h3F
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic spi_cs_n,
    output logic spi_sclk,
    output logic spi_mosi,
    input  logic spi_miso,
    output acc_t acc_out,
    output logic acc_valid,
    output logic overrun
);
    localparam int PW = $clog2(SAMPLE_PERIOD);
    localparam int CW = $clog2(2 * CLK_DIV);
    state_t               state_q, state_d;
    logic [PW-1:0]        per_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 cs_n_q, cs_n_d;
    acc_t                 acc_q, acc_d;
    logic                 valid_q, valid_d;
    logic                 ovr_q, ovr_d;
    logic                 tick, start, done;
    logic [DATA_BITS-1:0] data;
    assign tick  = per_q == '0;
    assign start = state_q == IDLE && tick && enable;
    esti_spi_shifter #(
        .CLK_DIV(CLK_DIV),
        .CMD    ({SPI_READ_BIT, REG_ADDR})
    ) u_shifter (
        .clk    (clk),
        .reset  (reset),
        .start_i(start),
        .miso_i (spi_miso),
        .sclk_o (spi_sclk),
        .mosi_o (spi_mosi),
        .done_o (done),
        .data_o (data)
    );
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - 1'b1;
        cs_n_d  = cs_n_q;
        acc_d   = acc_q;
        valid_d = 1'b0;
        ovr_d   = ovr_q | (tick && state_q != IDLE);
        case (state_q)
            IDLE: if (start) begin
                state_d = SETUP;
                cs_n_d  = 1'b0;
                cnt_d   = CW'(CLK_DIV - 1);
            end
            SETUP: if (cnt_q == '0) state_d = SHIFT;
            SHIFT: if (done) begin
                state_d = HOLD;
                cnt_d   = CW'(CLK_DIV - 1);
            end
            HOLD: if (cnt_q == '0) begin
                state_d = GAP;
                cs_n_d  = 1'b1;
                acc_d   = acc_t'(data);
                valid_d = 1'b1;
                cnt_d   = CW'(2 * CLK_DIV - 1);
            end
            GAP: if (cnt_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            per_q   <= PW'(SAMPLE_PERIOD - 1);
            cnt_q   <= '0;
            cs_n_q  <= 1'b1;
            acc_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            per_q   <= tick ? PW'(SAMPLE_PERIOD - 1) : per_q - 1'b1;
            cnt_q   <= cnt_d;
            cs_n_q  <= cs_n_d;
            acc_q   <= acc_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end
    assign spi_cs_n  = cs_n_q;
    assign acc_out   = acc_q;
    assign acc_valid = valid_q;
    assign overrun   = ovr_q;
endmodule

// File: tb/tb_esti_acc_spi_reader.sv
// tb_esti_acc_spi_reader: directed bench with an IMU model; instance a at period 200, instance b at period 60.
module tb_esti_acc_spi_reader;
    typedef struct {
        logic [15:0] word;
        logic [15:0] exp_acc;
        logic [23:0] exp_mosi;
    } vec_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b1;
    logic rb = 1'b1;
    logic en_b = 1'b1;
    logic cs_a, sclk_a, mosi_a, valid_a, ovr_a;
    logic miso_a = 1'b1;
    logic [15:0] acc_a;
    logic cs_b, sclk_b, mosi_b, valid_b, ovr_b;
    logic [15:0] acc_b;
    int ncmp = 0;
    int nerr = 0;
    int cyc = 0;
    logic [15:0] word = 16'hFF38;
    int fall_n = 0;
    int rises = 0;
    logic [23:0] mosi_cap = '0;
    int nval = 0;
    int falls = 0;
    logic prev_cs_a = 1'b1;
    logic [15:0] prev_acc = '0;
    logic prev_rst = 1'b0;
    int b_falls = 0;
    int b_valids = 0;
    int b_rise_cyc = 0;
    int min_gap = 1000000;
    logic prev_cs_b = 1'b1;
    esti_acc_spi_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(200), .REG_ADDR(7'h3F)) dut_a (
        .clk(clk), .reset(reset), .enable(enable),
        .spi_cs_n(cs_a), .spi_sclk(sclk_a), .spi_mosi(mosi_a), .spi_miso(miso_a),
        .acc_out(acc_a), .acc_valid(valid_a), .overrun(ovr_a)
    );
    esti_acc_spi_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(60), .REG_ADDR(7'h3F)) dut_b (
        .clk(clk), .reset(rb), .enable(en_b),
        .spi_cs_n(cs_b), .spi_sclk(sclk_b), .spi_mosi(mosi_b), .spi_miso(1'b1),
        .acc_out(acc_b), .acc_valid(valid_b), .overrun(ovr_b)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    // IMU model: shifts out 8 filler bits then the 16-bit word MSB first, changing on SCLK fall.
    always @(negedge cs_a) begin
        fall_n = 0;
        rises = 0;
        mosi_cap = '0;
    end
    always @(negedge sclk_a) if (cs_a === 1'b0) begin
        fall_n++;
        miso_a = (fall_n > 8 && fall_n <= 24) ? word[24-fall_n] : 1'b1;
    end
    always @(posedge sclk_a) if (cs_a === 1'b0) begin
        mosi_cap = {mosi_cap[22:0], mosi_a};
        rises++;
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (valid_a === 1'b1) nval++;
        if (prev_cs_a === 1'b1 && cs_a === 1'b0) falls++;
        prev_cs_a = cs_a;
        if (reset && prev_rst && acc_a !== prev_acc) chk("acc_changes_only_with_valid", {31'd0, valid_a}, 32'd1);
        prev_acc = acc_a;
        prev_rst = reset;
        if (valid_b === 1'b1) b_valids++;
        if (prev_cs_b === 1'b1 && cs_b === 1'b0) begin
            if (b_falls > 0 && cyc - b_rise_cyc < min_gap) min_gap = cyc - b_rise_cyc;
            b_falls++;
        end
        if (prev_cs_b === 1'b0 && cs_b === 1'b1) b_rise_cyc = cyc;
        prev_cs_b = cs_b;
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_cs_low(input int lim, output int n);
        n = 0;
        while (cs_a !== 1'b0 && n < lim) begin
            step();
            n++;
        end
        chk("cs_fall_seen", {31'd0, cs_a}, 32'd0);
    endtask
    task automatic wait_valid(input int lim, output int n);
        n = 0;
        while (valid_a !== 1'b1 && n < lim) begin
            step();
            n++;
        end
        chk("valid_seen", {31'd0, valid_a}, 32'd1);
    endtask
    initial begin
        vec_t vecs[3];
        int n;
        int nv0;
        int f0;
        vecs[0] = '{16'h7FFF, 16'h7FFF, 24'hBF0000};
        vecs[1] = '{16'h8000, 16'h8000, 24'hBF0000};
        vecs[2] = '{16'h0001, 16'h0001, 24'hBF0000};
        #2;
        reset = 1'b0;
        rb = 1'b0;
        #1;
        chk("rst_cs_n", {31'd0, cs_a}, 32'd1);
        chk("rst_sclk", {31'd0, sclk_a}, 32'd1);
        chk("rst_mosi", {31'd0, mosi_a}, 32'd0);
        chk("rst_acc", {16'd0, acc_a}, 32'd0);
        chk("rst_valid", {31'd0, valid_a}, 32'd0);
        chk("rst_overrun", {31'd0, ovr_a}, 32'd0);
        repeat (3) step();
        // Short-period instance: frames outlast the period, so ticks collide.
        rb = 1'b1;
        for (int i = 1; i <= 500; i++) begin
            step();
            if (i == 119) chk("b_no_overrun_before_2nd_tick", {31'd0, ovr_b}, 32'd0);
            if (i == 121) chk("b_overrun_after_2nd_tick", {31'd0, ovr_b}, 32'd1);
        end
        chk("b_frames_started", b_falls, 32'd4);
        chk("b_frames_completed", b_valids, 32'd3);
        chk("b_min_cs_high_ge4", {31'd0, min_gap >= 4}, 32'd1);
        chk("b_acc", {16'd0, acc_b}, 32'h0000FFFF);
        chk("b_overrun_sticky", {31'd0, ovr_b}, 32'd1);
        en_b = 1'b0;
        // First frame latency and content.
        reset = 1'b1;
        wait_cs_low(400, n);
        chk("first_cs_fall_cycle", n, 32'd200);
        wait_valid(200, n);
        chk("cs_fall_to_valid", n, 32'd100);
        chk("acc_ff38", {16'd0, acc_a}, 32'h0000FF38);
        chk("cs_rises_with_valid", {31'd0, cs_a}, 32'd1);
        chk("mosi_frame", {8'd0, mosi_cap}, 32'h00BF0000);
        chk("sclk_rises", rises, 32'd24);
        step();
        chk("valid_one_cycle", {31'd0, valid_a}, 32'd0);
        repeat (30) step();
        chk("acc_held", {16'd0, acc_a}, 32'h0000FF38);
        chk("sclk_idle_high", {31'd0, sclk_a}, 32'd1);
        // Table-driven boundary values.
        foreach (vecs[k]) begin
            word = vecs[k].word;
            wait_cs_low(300, n);
            nv0 = nval;
            wait_valid(200, n);
            chk($sformatf("vec%0d_latency", k), n, 32'd100);
            chk($sformatf("vec%0d_acc", k), {16'd0, acc_a}, {16'd0, vecs[k].exp_acc});
            chk($sformatf("vec%0d_mosi", k), {8'd0, mosi_cap}, {8'd0, vecs[k].exp_mosi});
            chk($sformatf("vec%0d_rises", k), rises, 32'd24);
            step();
            chk($sformatf("vec%0d_one_valid", k), nval - nv0, 32'd1);
        end
        // Reset in the middle of the data phase.
        word = 16'h1234;
        wait_cs_low(300, n);
        n = 0;
        while (rises < 12 && n < 200) begin
            step();
            n++;
        end
        chk("reached_bit12", {31'd0, rises >= 12}, 32'd1);
        nv0 = nval;
        reset = 1'b0;
        #1;
        chk("abort_cs_n", {31'd0, cs_a}, 32'd1);
        chk("abort_sclk", {31'd0, sclk_a}, 32'd1);
        chk("abort_acc", {16'd0, acc_a}, 32'd0);
        chk("abort_valid", {31'd0, valid_a}, 32'd0);
        repeat (10) step();
        chk("abort_no_valid", nval - nv0, 32'd0);
        reset = 1'b1;
        wait_cs_low(400, n);
        chk("post_abort_cs_fall", n, 32'd200);
        wait_valid(200, n);
        chk("post_abort_acc", {16'd0, acc_a}, 32'h00001234);
        chk("post_abort_nval", nval - nv0, 32'd0);
        step();
        chk("post_abort_one_valid", nval - nv0, 32'd1);
        // enable drops mid-frame: that frame completes, none follow.
        word = 16'hA5C3;
        wait_cs_low(300, n);
        repeat (30) step();
        enable = 1'b0;
        wait_valid(200, n);
        chk("enable_drop_acc", {16'd0, acc_a}, 32'h0000A5C3);
        f0 = falls;
        repeat (650) step();
        chk("enable_drop_no_frames", falls - f0, 32'd0);
        chk("overrun_a_clear", {31'd0, ovr_a}, 32'd0);
        // enable low from reset for three periods.
        reset = 1'b0;
        step();
        reset = 1'b1;
        f0 = falls;
        nv0 = nval;
        repeat (600) step();
        chk("disabled_no_cs", falls - f0, 32'd0);
        chk("disabled_no_valid", nval - nv0, 32'd0);
        chk("disabled_sclk_high", {31'd0, sclk_a}, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
